// File: rtl/serialize_pkg.sv
// serialize_pkg
//   Shared types and width helpers for serialize_arbiter, its round-robin
//   picker and its testbench.
//   - state_t : arbiter FSM state (IDLE waits for a grant, BUSY emits elements)
//   - idx_w   : index width for a count of n items (at least 1 bit)
//   - res_w   : result word width {requester idx, element idx, value}
package serialize_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int res_w(input int reqn, input int argn, input int argw);
      return idx_w(reqn) + idx_w(argn) + argw;
   endfunction

endpackage

// File: rtl/serialize_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches valid[] starting at ptr and
//   wrapping modulo N; the first set bit wins.
//   Ports:
//     valid  in  N    request vector
//     ptr    in  PW   highest-priority index this round (always < N)
//     grant  out N    one-hot grant, zero when nothing is valid
//     idx    out PW   binary index of the granted requester
//     any    out 1    at least one requester is valid
module rr_pick
   import serialize_pkg::*;
#(
   parameter int N  = 4,
   localparam int PW = idx_w(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   // One spare bit so ptr+i can exceed N before the explicit wrap; N need
   // not be a power of two, so plain truncation would be wrong.
   logic [PW:0]   sum;
   logic [PW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         cand = sum[PW-1:0];
         if (!any && valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/serialize_arbiter.sv
// serialize_arbiter
//   Shares one serial result stream between REQN vector requesters. A
//   round-robin grant captures one whole ARGN-element vector, which is then
//   emitted one element per handshake as {requester, element index, value}.
//   Optional feature macro: SERIALIZE_ARBITER_LAST_EN adds res_last.
//   Handshake: a transfer happens on a cycle where valid and ready are both
//   high at the rising clock edge; valid never depends on ready, and data is
//   held stable while valid is high and ready is low.
//   Ports:
//     clock      in   1               rising-edge clock
//     reset      in   1               synchronous, active-low
//     arg_valid  in   REQN            per-requester vector valid
//     arg_data   in   REQN*ARGN*ARGW  [REQN-1:0][ARGN-1:0][ARGW-1:0] vectors
//     arg_ready  out  REQN            one-hot accept, only in IDLE
//     res_valid  out  1               result element valid
//     res_data   out  RESW            {req idx, elem idx, value}
//     res_ready  in   1               downstream accepts result
//     dbg_state  out  1               FSM state (1 = BUSY)
//     res_last   out  1               last element flag (macro builds only)
module serialize_arbiter
   import serialize_pkg::*;
#(
   parameter int ARGW = 16,
   parameter int ARGN = 4,
   parameter int REQN = 4,
   localparam int RESW = res_w(REQN, ARGN, ARGW)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [REQN-1:0]          arg_valid,
   input  logic [REQN*ARGN*ARGW-1:0] arg_data,
   output logic [REQN-1:0]          arg_ready,
   output logic                     res_valid,
   output logic [RESW-1:0]          res_data,
   input  logic                     res_ready,
   output logic                     dbg_state
`ifdef SERIALIZE_ARBITER_LAST_EN
   ,
   output logic                     res_last
`endif
);

   localparam int PW = idx_w(REQN);
   localparam int KW = idx_w(ARGN);

   logic [REQN-1:0][ARGN-1:0][ARGW-1:0] arg_vecs;
   assign arg_vecs = arg_data;

   state_t                    state, state_nxt;
   logic [PW-1:0]             ptr, ptr_nxt;
   logic [PW-1:0]             req;
   logic [KW-1:0]             k, k_nxt;
   logic [ARGN-1:0][ARGW-1:0] vec;
   logic                      load;

   logic [REQN-1:0] grant;
   logic [PW-1:0]   gidx;
   logic            gany;

   rr_pick #(.N(REQN)) u_pick (
      .valid (arg_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // A grant only exists for a valid requester, so in IDLE gany alone
   // means the granted vector transfers this cycle.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      k_nxt     = k;
      load      = 1'b0;
      arg_ready = '0;
      case (state)
         IDLE: begin
            arg_ready = grant;
            if (gany) begin
               load      = 1'b1;
               k_nxt     = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (res_ready) begin
               if (k == KW'(ARGN-1)) begin
                  state_nxt = IDLE;
                  k_nxt     = '0;
                  ptr_nxt   = (req == PW'(REQN-1)) ? '0 : req + PW'(1);
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
         k     <= '0;
         req   <= '0;
         vec   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         k     <= k_nxt;
         if (load) begin
            req <= gidx;
            vec <= arg_vecs[gidx];
         end
      end
   end

   // Outputs come straight from registers; forced to zero outside BUSY.
   assign res_valid = (state == BUSY);
   assign res_data  = res_valid ? {req, k, vec[k]} : '0;
   assign dbg_state = (state == BUSY);

`ifdef SERIALIZE_ARBITER_LAST_EN
   assign res_last = res_valid && (k == KW'(ARGN-1));
`endif

endmodule

// File: tb/tb_serialize_arbiter.sv
// tb_serialize_arbiter
//   Directed testbench for serialize_arbiter with a transaction-level model:
//   each granted vector becomes ARGN queued result words, popped on every
//   accepted handshake. Honors SERIALIZE_ARBITER_LAST_EN.
module tb_serialize_arbiter;
   import serialize_pkg::*;

   localparam int ARGW = 16;
   localparam int ARGN = 4;
   localparam int REQN = 4;
   localparam int PW   = idx_w(REQN);
   localparam int KW   = idx_w(ARGN);
   localparam int RESW = res_w(REQN, ARGN, ARGW);

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [REQN-1:0] arg_valid = '0;
   logic [REQN-1:0][ARGN-1:0][ARGW-1:0] vecs = '0;
   logic [REQN-1:0] arg_ready;
   logic            res_valid;
   logic [RESW-1:0] res_data;
   logic            res_ready = 1'b0;
   logic            dbg_state;
`ifdef SERIALIZE_ARBITER_LAST_EN
   logic            res_last;
`endif

   int checks   = 0;
   int failures = 0;
   bit auto_drop    = 1'b1;
   bit toggle_ready = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   serialize_arbiter #(.ARGW(ARGW), .ARGN(ARGN), .REQN(REQN)) dut (
      .clock     (clock),
      .reset     (reset),
      .arg_valid (arg_valid),
      .arg_data  (vecs),
      .arg_ready (arg_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .dbg_state (dbg_state)
`ifdef SERIALIZE_ARBITER_LAST_EN
      ,
      .res_last  (res_last)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   function automatic int pick(input logic [REQN-1:0] v, input int p);
      int c;
      for (int i = 0; i < REQN; i++) begin
         c = (p + i) % REQN;
         if (v[PW'(c)]) return c;
      end
      return -1;
   endfunction

   logic [RESW-1:0] exp_q[$];
   bit busy_m = 1'b0;
   int ptr_m  = 0;
   int req_m  = 0;
   bit live   = 1'b0;

   always @(posedge clock) begin
      int g;
      if (!reset) begin
         exp_q.delete();
         busy_m = 1'b0;
         ptr_m  = 0;
         live   = 1'b1;
      end else if (live) begin
         if (!busy_m) begin
            g = pick(arg_valid, ptr_m);
            if (g >= 0) begin
               for (int kk = 0; kk < ARGN; kk++)
                  exp_q.push_back({PW'(g), KW'(kk), vecs[PW'(g)][KW'(kk)]});
               busy_m = 1'b1;
               req_m  = g;
            end
         end else if (res_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               busy_m = 1'b0;
               ptr_m  = (req_m + 1) % REQN;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      logic [REQN-1:0] exp_rdy;
      logic [RESW-1:0] exp_dat;
      int g;
      if (live) begin
         exp_rdy = '0;
         exp_dat = '0;
         if (!busy_m) begin
            g = pick(arg_valid, ptr_m);
            if (g >= 0) exp_rdy[PW'(g)] = 1'b1;
         end else begin
            exp_dat = exp_q[0];
         end
         chk("arg_ready", 64'(arg_ready), 64'(exp_rdy));
         chk("res_valid", 64'(res_valid), 64'(busy_m));
         chk("res_data", 64'(res_data), 64'(exp_dat));
`ifdef SERIALIZE_ARBITER_LAST_EN
         chk("res_last", 64'(res_last), 64'(busy_m && exp_q.size() == 1));
`endif
      end
   end

   // ---------------- monitor logs ----------------
   int gnt_q[$];
   int gnt_t[$];
   logic [RESW-1:0] acc_q[$];
   int acc_t[$];
   bit last_q[$];
   int tcount = 0;

   always @(negedge clock) begin
      tcount++;
      if (reset) begin
         for (int i = 0; i < REQN; i++) begin
            if (arg_valid[i] && arg_ready[i]) begin
               gnt_q.push_back(i);
               gnt_t.push_back(tcount);
            end
         end
         if (res_valid && res_ready) begin
            acc_q.push_back(res_data);
            acc_t.push_back(tcount);
`ifdef SERIALIZE_ARBITER_LAST_EN
            last_q.push_back(res_last);
`else
            last_q.push_back(1'b0);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      logic [REQN-1:0] xfer;
      @(negedge clock);
      xfer = arg_valid & arg_ready;
      @(posedge clock);
      #1;
      if (auto_drop) arg_valid = arg_valid & ~xfer;
      if (toggle_ready) res_ready = ~res_ready;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_gnt(input int target, input string name);
      int n;
      n = 0;
      while (gnt_q.size() < target && n < 200) begin
         step();
         n++;
      end
      chk(name, 64'(gnt_q.size()), 64'(target));
   endtask

   task automatic wait_acc(input int target, input string name);
      int n;
      n = 0;
      while (acc_q.size() < target && n < 200) begin
         step();
         n++;
      end
      chk(name, 64'(acc_q.size()), 64'(target));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [RESW-1:0] lit1[4];
      logic [RESW-1:0] lit4[4];
      logic [RESW-1:0] lit5[8];
      int ord2[5];
      int ord3[4];
      int bg;
      int ba;

      lit1 = '{20'h40010, 20'h50011, 20'h60012, 20'h70013};
      lit4 = '{20'h800A0, 20'h900A1, 20'hA00A2, 20'hB00A3};
      lit5 = '{20'h00050, 20'h10051, 20'h20052, 20'h30053,
               20'hC0060, 20'hD0061, 20'hE0062, 20'hF0063};
      ord2 = '{0, 1, 2, 3, 0};
      ord3 = '{3, 0, 1, 0};

      reset     = 1'b0;
      res_ready = 1'b1;
      run(3);
      reset = 1'b1;
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_arg_ready", 64'(arg_ready), 64'd0);
`ifdef SERIALIZE_ARBITER_LAST_EN
      chk("rst_res_last", 64'(res_last), 64'd0);
`endif

      // 1: single requester 1
      for (int n = 0; n < ARGN; n++) vecs[1][n] = 16'h10 + 16'(n);
      bg = gnt_q.size();
      ba = acc_q.size();
      arg_valid = 4'b0010;
      wait_acc(ba + 4, "t1_wait");
      run(2);
      chk("t1_grants", 64'(gnt_q.size()), 64'(bg + 1));
      chk("t1_grant_id", 64'(gnt_q[bg]), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("t1_elem", 64'(acc_q[ba+i]), 64'(lit1[i]));
         chk("t1_last_flag", 64'(last_q[ba+i]),
`ifdef SERIALIZE_ARBITER_LAST_EN
             64'(i == 3)
`else
             64'd0
`endif
         );
      end
      chk("t1_latency", 64'(acc_t[ba] - gnt_t[bg]), 64'd1);
      chk("t1_consecutive", 64'(acc_t[ba+3] - acc_t[ba]), 64'd3);

      // 2: all four held from ptr=0
      do_reset();
      for (int r = 0; r < REQN; r++)
         for (int n = 0; n < ARGN; n++) vecs[r][n] = 16'(r * 256 + 32 + n);
      bg = gnt_q.size();
      auto_drop = 1'b0;
      arg_valid = 4'b1111;
      wait_gnt(bg + 5, "t2_wait");
      arg_valid = '0;
      auto_drop = 1'b1;
      run(8);
      for (int i = 0; i < 5; i++) chk("t2_order", 64'(gnt_q[bg+i]), 64'(ord2[i]));
      for (int i = 0; i < 4; i++) chk("t2_period", 64'(gnt_t[bg+i+1] - gnt_t[bg+i]), 64'd5);
      chk("t2_model_ptr", 64'(ptr_m), 64'd1);

      // 3: ptr=1 with 4'b1001 -> 3 then 0, leaving ptr=1 (1 beats 0 next)
      for (int n = 0; n < ARGN; n++) vecs[3][n] = 16'h30 + 16'(n);
      bg = gnt_q.size();
      arg_valid = 4'b1001;
      wait_gnt(bg + 2, "t3_wait_a");
      run(10);
      chk("t3_model_ptr", 64'(ptr_m), 64'd1);
      arg_valid = 4'b0011;
      wait_gnt(bg + 4, "t3_wait_b");
      run(10);
      for (int i = 0; i < 4; i++) chk("t3_order", 64'(gnt_q[bg+i]), 64'(ord3[i]));

      // 4: res_ready toggles every cycle
      for (int n = 0; n < ARGN; n++) vecs[2][n] = 16'hA0 + 16'(n);
      ba = acc_q.size();
      res_ready    = 1'b0;
      toggle_ready = 1'b1;
      arg_valid    = 4'b0100;
      wait_acc(ba + 4, "t4_wait");
      toggle_ready = 1'b0;
      res_ready    = 1'b1;
      run(4);
      chk("t4_count", 64'(acc_q.size()), 64'(ba + 4));
      for (int i = 0; i < 4; i++) chk("t4_elem", 64'(acc_q[ba+i]), 64'(lit4[i]));

      // 5: reset after two elements, then re-offer
      for (int n = 0; n < ARGN; n++) vecs[0][n] = 16'h50 + 16'(n);
      for (int n = 0; n < ARGN; n++) vecs[3][n] = 16'h60 + 16'(n);
      ba = acc_q.size();
      arg_valid = 4'b0001;
      wait_acc(ba + 2, "t5_wait_a");
      reset = 1'b0;
      step();
      chk("t5_rst_valid", 64'(res_valid), 64'd0);
      chk("t5_rst_state", 64'(dbg_state), 64'd0);
`ifdef SERIALIZE_ARBITER_LAST_EN
      chk("t5_rst_last", 64'(res_last), 64'd0);
`endif
      reset = 1'b1;
      bg = gnt_q.size();
      ba = acc_q.size();
      arg_valid = 4'b1001;
      wait_acc(ba + 8, "t5_wait_b");
      run(3);
      chk("t5_first_grant", 64'(gnt_q[bg]), 64'd0);
      chk("t5_second_grant", 64'(gnt_q[bg+1]), 64'd3);
      for (int i = 0; i < 8; i++) chk("t5_elem", 64'(acc_q[ba+i]), 64'(lit5[i]));
`ifdef SERIALIZE_ARBITER_LAST_EN
      chk("t6_idle_last", 64'(res_last), 64'd0);
`endif

      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
